topk_ctrl: RTL and testbench
============================

TOPK_CTRL -- requirements
Module: topk_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the data bits per entry.
REQ-002 Parameter PRIO_WIDTH, default 32, SHALL set the bits per priority (unsigned).
REQ-003 Parameter TOT_SIZE, default 4, SHALL set the maximum number of retained entries (K).
REQ-004 sink_clk  in  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-006 sink_valid  in  1  SHALL mark an offered input beat.
REQ-007 sink_ready  out  1  SHALL mark that the block accepts a beat this cycle.
REQ-008 sink_data  in  DATA_WIDTH  SHALL carry the input payload.
REQ-009 sink_prio  in  PRIO_WIDTH  SHALL carry the input priority.
REQ-010 sink_last  in  1  SHALL mark the final beat of a frame.
REQ-011 flush  in  1  SHALL discard all stored entries and abort the current frame.
REQ-012 source_valid  out  1  SHALL mark a valid output entry.
REQ-013 source_ready  in  1  SHALL be the downstream acceptance.
REQ-014 source_data  out  DATA_WIDTH, source_prio  out  PRIO_WIDTH  SHALL carry the head entry.
REQ-015 source_last  out  1  SHALL mark the final entry of a drained frame.
REQ-016 fill_level  out  $clog2(TOT_SIZE+1)  SHALL report the count of stored entries.
REQ-017 drop_count  out  16  SHALL count discarded candidates (saturating at 16'hFFFF).

Function
REQ-018 The FSM SHALL have exactly two states: FILL and DRAIN.
REQ-019 FILL: sink_ready=1, source_valid=0; a beat transfers when sink_valid&sink_ready.
REQ-020 Each transferred beat SHALL be inserted, in the same cycle, at the first slot i where slot i is empty or sink_prio > prio[i]; lower slots shift down by one.
REQ-021 Equal priorities SHALL keep arrival order (earlier beat ranks higher).
REQ-022 If the buffer is full and sink_prio <= lowest stored prio, the beat SHALL be dropped (drop_count+1); if inserted while full, the evicted tail SHALL count as a drop (drop_count+1).
REQ-023 fill_level SHALL increment per insertion while not full and saturate at TOT_SIZE.
REQ-024 A transferred beat with sink_last=1 SHALL be processed normally and move the FSM to DRAIN on the next cycle.
REQ-025 DRAIN: sink_ready=0, source_valid=1, source_* SHALL reflect slot 0 combinationally from registers.
REQ-026 source_last SHALL be 1 when fill_level==1 in DRAIN.
REQ-027 On source_valid&source_ready, slot 0 SHALL be popped (slots shift up, fill_level-1) effective next cycle.
REQ-028 Output SHALL hold stable while source_valid=1 and source_ready=0.
REQ-029 The pop with source_last=1 SHALL return the FSM to FILL on the next cycle with the buffer empty.
REQ-030 flush=1 in any state SHALL empty the buffer, set fill_level=0, and force FILL next cycle; it SHALL override a simultaneous insert or pop, which then has no effect and is not counted as a drop.
REQ-031 Latency: last beat accepted in cycle N -> source_valid=1 in cycle N+1.

Reset
REQ-032 With reset=0 at a clock edge: state=FILL, all slots empty, fill_level=0, drop_count=0, source_valid=0, source_last=0, sink_ready=1 from the following cycle; reset SHALL override flush and all handshakes, including mid-DRAIN.

Structure
REQ-033 Package topk_pkg SHALL hold the FSM state enum and the entry struct (data, prio, valid).
REQ-034 The slot array with insert/pop/clear SHALL be sub-module topk_sorter; topk_ctrl SHALL hold the FSM, counters and handshakes.

Verification (TOT_SIZE=4)
REQ-035 Beats prio 5,9,1,7,3(last) -> drains 9,7,5,3 with last on 3; drop_count=1 (evicted 1).
REQ-036 Beats (A,4),(B,4),(C,4)(last) -> drains A,B,C in order; fill_level 3 then 0.
REQ-037 Single beat prio 0 with sink_last -> one output, source_last=1, FSM back to FILL next cycle.
REQ-038 DRAIN with source_ready low 5 cycles -> source_* stable; sink_ready=0 throughout.
REQ-039 flush asserted mid-DRAIN with source_ready=1 -> no pop counted, fill_level=0, sink_ready=1 next cycle.
REQ-040 reset=0 during FILL with 3 entries -> fill_level=0, drop_count=0, new frame drains only post-reset beats.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types for the top-K priority buffer.
// Holds the FSM state enum, the slot entry layout and its default widths.
package topk_pkg;

    // Default payload/priority widths; the entry layout below is built from them,
    // so topk_ctrl's width parameters are expected to stay at these values.
    localparam int DATA_W = 10;
    localparam int PRIO_W = 32;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PRIO_W-1:0] prio;
        logic              valid;
    } entry_t;

endpackage

// File: rtl/topk_if.sv
// Sink/source streaming bundle for topk_ctrl.
// master drives beats in and accepts entries out; slave is the block side.
interface topk_if
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int PRIO_WIDTH = PRIO_W
);
    logic                  sink_valid;
    logic                  sink_ready;
    logic [DATA_WIDTH-1:0] sink_data;
    logic [PRIO_WIDTH-1:0] sink_prio;
    logic                  sink_last;

    logic                  source_valid;
    logic                  source_ready;
    logic [DATA_WIDTH-1:0] source_data;
    logic [PRIO_WIDTH-1:0] source_prio;
    logic                  source_last;

    modport master (
        output sink_valid, sink_data, sink_prio, sink_last, source_ready,
        input  sink_ready, source_valid, source_data, source_prio, source_last
    );

    modport slave (
        input  sink_valid, sink_data, sink_prio, sink_last, source_ready,
        output sink_ready, source_valid, source_data, source_prio, source_last
    );
endinterface

// File: rtl/topk_sorter.sv
// Sorted slot array: slot 0 holds the highest priority, ties keep arrival order.
// Ports: clk, reset (sync, active-low), clear, ins + cand, pop, head (slot 0).
module topk_sorter
    import topk_pkg::*;
#(
    parameter int TOT_SIZE = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   ins,
    input  logic   pop,
    input  entry_t cand,
    output entry_t head
);

    entry_t              slots [TOT_SIZE];
    entry_t              nxt   [TOT_SIZE];
    entry_t              above [TOT_SIZE];
    entry_t              below [TOT_SIZE];
    logic [TOT_SIZE-1:0] take;
    logic [TOT_SIZE-1:0] take_above;

    // Valid slots are contiguous and descending, so take[] is a thermometer:
    // once the candidate beats a slot (or hits an empty one) it beats all
    // later ones. The first set bit is the insertion point; slots after it
    // shift down. A full buffer with no set bit drops the candidate.
    always_comb begin
        for (int i = 0; i < TOT_SIZE; i++) begin
            take[i] = !slots[i].valid || (cand.prio > slots[i].prio);
        end
    end

    always_comb begin
        above[0]      = '0;
        take_above[0] = 1'b0;
        below[TOT_SIZE-1] = '0;
        for (int i = 1; i < TOT_SIZE; i++) begin
            above[i]      = slots[i-1];
            take_above[i] = take[i-1];
        end
        for (int i = 0; i < TOT_SIZE - 1; i++) begin
            below[i] = slots[i+1];
        end
    end

    always_comb begin
        for (int i = 0; i < TOT_SIZE; i++) begin
            nxt[i] = slots[i];
        end
        if (clear) begin
            for (int i = 0; i < TOT_SIZE; i++) begin
                nxt[i] = '0;
            end
        end else if (ins) begin
            for (int i = 0; i < TOT_SIZE; i++) begin
                if (take[i]) begin
                    nxt[i] = take_above[i] ? above[i] : cand;
                end
            end
        end else if (pop) begin
            for (int i = 0; i < TOT_SIZE; i++) begin
                nxt[i] = below[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TOT_SIZE; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TOT_SIZE; i++) begin
                slots[i] <= nxt[i];
            end
        end
    end

    assign head = slots[0];

endmodule

// File: rtl/topk_ctrl.sv
// Top-K frame buffer: collects a frame keeping the K highest priorities, then drains them.
// Ports: sink_clk, reset (sync, active-low), bus (topk_if.slave), flush, fill_level, drop_count.
module topk_ctrl
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int PRIO_WIDTH = PRIO_W,
    parameter int TOT_SIZE   = 4,
    localparam int LVL_W     = $clog2(TOT_SIZE + 1)
) (
    input  logic             sink_clk,
    input  logic             reset,
    topk_if.slave            bus,
    input  logic             flush,
    output logic [LVL_W-1:0] fill_level,
    output logic [15:0]      drop_count
);

    state_t state;
    state_t state_nxt;

    entry_t cand;
    entry_t head;

    logic in_fire;
    logic out_fire;
    logic full;
    logic sink_ready;
    logic source_valid;
    logic source_last;

    assign in_fire  = bus.sink_valid && (state == FILL);
    assign out_fire = bus.source_ready && source_valid;
    assign full     = (fill_level == LVL_W'(TOT_SIZE));

    always_comb begin
        cand       = '0;
        cand.data  = bus.sink_data;
        cand.prio  = bus.sink_prio;
        cand.valid = 1'b1;
    end

    // Clear has priority inside the sorter, so a flush cancels a same-cycle
    // insert or pop without extra gating here.
    topk_sorter #(
        .TOT_SIZE (TOT_SIZE)
    ) u_sorter (
        .clk   (sink_clk),
        .reset (reset),
        .clear (flush),
        .ins   (in_fire),
        .pop   (out_fire),
        .cand  (cand),
        .head  (head)
    );

    always_ff @(posedge sink_clk) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sink_ready   = 1'b0;
        source_valid = 1'b0;
        source_last  = 1'b0;
        unique case (state)
            FILL: begin
                sink_ready = 1'b1;
                if (bus.sink_valid && bus.sink_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                source_valid = head.valid;
                source_last  = (fill_level == LVL_W'(1));
                if (bus.source_ready && source_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        if (flush) begin
            state_nxt = FILL;
        end
    end

    // Any beat taken while full costs exactly one entry: either the beat
    // itself or the evicted tail.
    always_ff @(posedge sink_clk) begin
        if (!reset) begin
            fill_level <= '0;
            drop_count <= '0;
        end else if (flush) begin
            fill_level <= '0;
        end else begin
            if (in_fire && !full) begin
                fill_level <= fill_level + LVL_W'(1);
            end else if (out_fire) begin
                fill_level <= fill_level - LVL_W'(1);
            end
            if (in_fire && full && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign bus.sink_ready   = sink_ready;
    assign bus.source_valid = source_valid;
    assign bus.source_last  = source_last;
    assign bus.source_data  = head.data;
    assign bus.source_prio  = head.prio;

endmodule

// File: tb/tb_topk_ctrl.sv
// Directed bench for topk_ctrl with TOT_SIZE=4.
// Drives frames through topk_if, checks drain order, handshakes, flush and reset.
module tb_topk_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  fill_level;
    logic [15:0] drop_count;

    int n_tests;
    int n_fail;

    logic [31:0] exp_p [$];
    logic [31:0] exp_d [$];

    topk_if #(.DATA_WIDTH(10), .PRIO_WIDTH(32)) bus ();

    topk_ctrl #(
        .DATA_WIDTH (10),
        .PRIO_WIDTH (32),
        .TOT_SIZE   (4)
    ) dut (
        .sink_clk   (clk),
        .reset      (rst),
        .bus        (bus),
        .flush      (flush),
        .fill_level (fill_level),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] d, input logic [31:0] p,
                        input logic l);
        bus.sink_valid = 1'b1;
        bus.sink_data  = d;
        bus.sink_prio  = p;
        bus.sink_last  = l;
        tick();
        bus.sink_valid = 1'b0;
        bus.sink_last  = 1'b0;
    endtask

    task automatic expect_out(input logic [9:0] d, input logic [31:0] p);
        exp_d.push_back(32'(d));
        exp_p.push_back(p);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.source_valid && k < 20) begin
            tick();
            k++;
        end
        if (!bus.source_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_p.size();
        bus.source_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_valid(tag);
            check({tag, "_prio"}, bus.source_prio, exp_p[i]);
            check({tag, "_data"}, 32'(bus.source_data), exp_d[i]);
            check({tag, "_last"}, 32'(bus.source_last), 32'(i == n - 1));
            tick();
        end
        bus.source_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(bus.source_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.sink_ready), 32'd1);
        check({tag, "_idle_fill"}, 32'(fill_level), 32'd0);
        exp_p.delete();
        exp_d.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        flush = 1'b0;
        bus.sink_valid   = 1'b0;
        bus.sink_data    = '0;
        bus.sink_prio    = '0;
        bus.sink_last    = 1'b0;
        bus.source_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_sink_ready", 32'(bus.sink_ready), 32'd1);
        check("rst_src_valid", 32'(bus.source_valid), 32'd0);
        check("rst_src_last", 32'(bus.source_last), 32'd0);

        // Sorted drain with one eviction
        send(10'd10, 32'd5, 1'b0);
        send(10'd11, 32'd9, 1'b0);
        send(10'd12, 32'd1, 1'b0);
        send(10'd13, 32'd7, 1'b0);
        check("sort_full_fill", 32'(fill_level), 32'd4);
        send(10'd14, 32'd3, 1'b1);
        check("sort_latency", 32'(bus.source_valid), 32'd1);
        check("sort_sink_ready", 32'(bus.sink_ready), 32'd0);
        check("sort_fill", 32'(fill_level), 32'd4);
        check("sort_drop", 32'(drop_count), 32'd1);
        expect_out(10'd11, 32'd9);
        expect_out(10'd13, 32'd7);
        expect_out(10'd10, 32'd5);
        expect_out(10'd14, 32'd3);
        drain("sort");

        // Equal priorities keep arrival order
        send(10'h0A, 32'd4, 1'b0);
        send(10'h0B, 32'd4, 1'b0);
        send(10'h0C, 32'd4, 1'b1);
        check("tie_fill", 32'(fill_level), 32'd3);
        expect_out(10'h0A, 32'd4);
        expect_out(10'h0B, 32'd4);
        expect_out(10'h0C, 32'd4);
        drain("tie");

        // Single zero-priority beat
        send(10'h3FF, 32'd0, 1'b1);
        check("one_last", 32'(bus.source_last), 32'd1);
        expect_out(10'h3FF, 32'd0);
        drain("one");

        // Backpressure holds the head stable
        send(10'd1, 32'd20, 1'b0);
        send(10'd2, 32'd30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_prio", bus.source_prio, 32'd30);
            check("hold_data", 32'(bus.source_data), 32'd2);
            check("hold_sink_ready", 32'(bus.sink_ready), 32'd0);
            tick();
        end
        expect_out(10'd2, 32'd30);
        expect_out(10'd1, 32'd20);
        drain("hold");

        // Flush mid-DRAIN overrides the pop
        send(10'd5, 32'd50, 1'b0);
        send(10'd6, 32'd60, 1'b1);
        check("fl_pre_fill", 32'(fill_level), 32'd2);
        bus.source_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.source_ready = 1'b0;
        check("fl_fill", 32'(fill_level), 32'd0);
        check("fl_sink_ready", 32'(bus.sink_ready), 32'd1);
        check("fl_src_valid", 32'(bus.source_valid), 32'd0);
        check("fl_drop", 32'(drop_count), 32'd1);

        // Flush with a beat into a full buffer: no insert, no drop
        send(10'd1, 32'd1, 1'b0);
        send(10'd2, 32'd2, 1'b0);
        send(10'd3, 32'd3, 1'b0);
        send(10'd4, 32'd4, 1'b0);
        flush = 1'b1;
        send(10'd9, 32'd99, 1'b0);
        flush = 1'b0;
        check("flin_fill", 32'(fill_level), 32'd0);
        check("flin_drop", 32'(drop_count), 32'd1);
        send(10'd7, 32'd70, 1'b1);
        expect_out(10'd7, 32'd70);
        drain("flin");

        // Reset during FILL with three entries
        send(10'd1, 32'd1, 1'b0);
        send(10'd2, 32'd2, 1'b0);
        send(10'd3, 32'd3, 1'b0);
        check("rf_pre_fill", 32'(fill_level), 32'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rf_fill", 32'(fill_level), 32'd0);
        check("rf_drop", 32'(drop_count), 32'd0);
        check("rf_sink_ready", 32'(bus.sink_ready), 32'd1);
        send(10'd8, 32'd8, 1'b1);
        expect_out(10'd8, 32'd8);
        drain("rf");

        // Full buffer drops a beat equal to the tail priority
        send(10'd21, 32'd10, 1'b0);
        send(10'd22, 32'd20, 1'b0);
        send(10'd23, 32'd30, 1'b0);
        send(10'd24, 32'd40, 1'b0);
        send(10'd25, 32'd10, 1'b1);
        check("eq_drop", 32'(drop_count), 32'd1);
        check("eq_fill", 32'(fill_level), 32'd4);
        expect_out(10'd24, 32'd40);
        expect_out(10'd23, 32'd30);
        expect_out(10'd22, 32'd20);
        expect_out(10'd21, 32'd10);
        drain("eq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
